multicycle_mainfsm: RTL and testbench
=====================================

MULTICYCLE_MAINFSM -- requirements
Module: multicycle_mainfsm

Interface
REQ-001 SHALL have parameter MAXWAIT, default 15, giving the maximum memory-wait cycles (1..255) before timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Op, input, 2 bits: instruction class (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-005 SHALL have port Funct, input, 6 bits: Funct[5] is I (immediate), Funct[0] is S/L (set-flags / load).
REQ-006 SHALL have port MemReady, input, 1 bit: memory completes the current access this cycle.
REQ-007 SHALL have ports IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, each output, 1 bit: datapath and condlogic controls.
REQ-008 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, each output, 2 bits (ALUSrcA uses bit 0 only; bit 1 is 0): datapath mux selects.
REQ-009 SHALL have ports InstrDone, Undef, MemTimeout, each output, 1 bit: one-cycle status pulses.

Function
REQ-010 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10; IRWrite=NextPC=MemReady; go to DECODE when MemReady=1, else stay in FETCH.
REQ-012 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next state is MEMADR for Op=01, EXECUTEI for Op=00 with Funct[5]=1, EXECUTER for Op=00 with Funct[5]=0, BRANCH for Op=10, and FETCH for Op=11.
REQ-013 DECODE with Op=11 SHALL pulse Undef=1 and InstrDone=1 for that cycle.
REQ-014 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0; go to MEMREAD if Funct[0]=1, else to MEMWRITE.
REQ-015 MEMREAD: AdrSrc=1, ResultSrc=00; go to MEMWB on MemReady=1, else hold.
REQ-016 MEMWB: ResultSrc=01, RegW=1, InstrDone=1; go to FETCH.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 for every cycle in the state; on MemReady=1 pulse InstrDone and go to FETCH, else hold.
REQ-018 EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Both go to ALUWB.
REQ-019 ALUWB: ResultSrc=00, RegW=1, InstrDone=1; go to FETCH.
REQ-020 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1, InstrDone=1; go to FETCH.
REQ-021 Any control not listed for a state SHALL be 0; all outputs except the MemReady-qualified strobes are Moore-decoded from state.
REQ-022 A wait counter (width ceil(log2(MAXWAIT+1))) SHALL clear on entry to FETCH, MEMREAD or MEMWRITE, increment each cycle MemReady=0 in those states, and saturate, never wrap.
REQ-023 When the counter equals MAXWAIT and MemReady=0, the block SHALL pulse MemTimeout=1, suppress IRWrite/NextPC/RegW, and go to FETCH next cycle; MemW remains 1 that cycle.
REQ-024 MemReady=1 in the same cycle the counter reaches MAXWAIT SHALL complete normally, with no MemTimeout.
REQ-025 Op and Funct SHALL be sampled only in DECODE and MEMADR; changes in other states have no effect.

Reset
REQ-026 reset=1 at a clock edge SHALL force state to FETCH and clear the wait counter, regardless of current state (including mid-access).
REQ-027 While reset=1, IRWrite, NextPC, RegW, MemW, Branch, InstrDone, Undef and MemTimeout SHALL be 0; mux selects show FETCH values.
REQ-028 The first cycle after reset deasserts SHALL be FETCH with counter 0.

Verification
REQ-029 ADD reg (Op=00, Funct=000000), MemReady=1 always -> FETCH, DECODE, EXECUTER, ALUWB (RegW=1, InstrDone=1), FETCH; 4 cycles per instruction.
REQ-030 LDR (Op=01, Funct[0]=1), MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB RegW=1, ResultSrc=01.
REQ-031 STR (Op=01, Funct[0]=0), MemReady=0 for 14 cycles then 1 -> MemW=1 for 15 cycles; InstrDone on the 15th; no MemTimeout.
REQ-032 FETCH with MemReady stuck 0, MAXWAIT=15 -> MemTimeout pulse on the 16th FETCH cycle; IRWrite is never 1; FETCH re-entered with counter 0.
REQ-033 Op=11 -> DECODE pulses Undef=1 and InstrDone=1; next state FETCH; RegW, MemW and Branch stay 0.
REQ-034 reset=1 asserted during MEMWRITE -> MemW=0 in the reset cycle; state is FETCH on the following cycle; B instruction (Op=10) afterwards gives Branch=1 exactly in the third cycle.

Source files
------------

// File: rtl/multicycle_mainfsm.sv
// Main control FSM for a multicycle ARM-style processor.
// Sequences fetch, decode, memory, ALU and branch steps, and bounds every
// memory wait with a saturating counter that forces a timeout back to FETCH.
module multicycle_mainfsm #(
   parameter int MAXWAIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       InstrDone,
   output logic       Undef,
   output logic       MemTimeout
);

   localparam int CW = $clog2(MAXWAIT + 1);

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BRANCH
   } state_t;

   state_t         state;
   state_t         nextstate;
   logic [CW-1:0]  waitcnt;
   logic           waiting;
   logic           timeout;
   logic           unusedFunct;

   // Only the immediate and load/set-flags bits steer this FSM.
   assign unusedFunct = ^Funct[4:1];

   // A memory wait is outstanding in these states; it times out once the
   // counter has reached the limit and memory is still not ready.
   assign waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign timeout = waiting && !MemReady && (waitcnt == CW'(MAXWAIT));

   // State register; reset returns to FETCH from anywhere, even mid-access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= nextstate;
      end
   end

   // Wait counter: cleared on any state change or timeout (so entry into a
   // wait state always starts from zero), counts stalled cycles, saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         waitcnt <= '0;
      end else if ((nextstate != state) || timeout) begin
         waitcnt <= '0;
      end else if (waiting && !MemReady && (waitcnt != CW'(MAXWAIT))) begin
         waitcnt <= waitcnt + CW'(1);
      end
   end

   // Next-state and control decode; reset overrides everything with idle FETCH controls.
   always_comb begin
      nextstate  = state;
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      Branch     = 1'b0;
      ALUOp      = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      InstrDone  = 1'b0;
      Undef      = 1'b0;
      MemTimeout = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (MemReady) begin
               IRWrite   = 1'b1;
               NextPC    = 1'b1;
               nextstate = DECODE;
            end else if (timeout) begin
               MemTimeout = 1'b1;
               nextstate  = FETCH;
            end
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b00:   nextstate = Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   nextstate = MEMADR;
               2'b10:   nextstate = BRANCH;
               default: begin
                  Undef     = 1'b1;
                  InstrDone = 1'b1;
                  nextstate = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcB   = 2'b01;
            nextstate = Funct[0] ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) begin
               nextstate = MEMWB;
            end else if (timeout) begin
               MemTimeout = 1'b1;
               nextstate  = FETCH;
            end
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
            InstrDone = 1'b1;
            nextstate = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
            if (MemReady) begin
               InstrDone = 1'b1;
               nextstate = FETCH;
            end else if (timeout) begin
               MemTimeout = 1'b1;
               nextstate  = FETCH;
            end
         end
         EXECUTER: begin
            ALUOp     = 1'b1;
            nextstate = ALUWB;
         end
         EXECUTEI: begin
            ALUOp     = 1'b1;
            ALUSrcB   = 2'b01;
            nextstate = ALUWB;
         end
         ALUWB: begin
            RegW      = 1'b1;
            InstrDone = 1'b1;
            nextstate = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
            InstrDone = 1'b1;
            nextstate = FETCH;
         end
         default: begin
            nextstate = FETCH;
         end
      endcase
      if (reset) begin
         IRWrite    = 1'b0;
         NextPC     = 1'b0;
         RegW       = 1'b0;
         MemW       = 1'b0;
         Branch     = 1'b0;
         ALUOp      = 1'b0;
         AdrSrc     = 1'b0;
         ResultSrc  = 2'b10;
         ALUSrcA    = 2'b01;
         ALUSrcB    = 2'b10;
         InstrDone  = 1'b0;
         Undef      = 1'b0;
         MemTimeout = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Self-checking bench for multicycle_mainfsm: a table of per-cycle vectors
// plus hand-written wait/timeout/reset sequences, checked via a scoreboard.
module tb_multicycle_mainfsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'b000000;
   logic       MemReady = 1'b0;
   logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic       InstrDone, Undef, MemTimeout;

   // Packed view: {IRWrite,NextPC,RegW,MemW,Branch,ALUOp,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,InstrDone,Undef,MemTimeout}
   logic [15:0] act;
   assign act = {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
                 ResultSrc, ALUSrcA, ALUSrcB, InstrDone, Undef, MemTimeout};

   localparam logic [15:0] F_B   = {7'b0000000, 2'b10, 2'b01, 2'b10, 3'b000};
   localparam logic [15:0] F_R   = {7'b1100000, 2'b10, 2'b01, 2'b10, 3'b000};
   localparam logic [15:0] F_T   = {7'b0000000, 2'b10, 2'b01, 2'b10, 3'b001};
   localparam logic [15:0] DEC   = {7'b0000000, 2'b10, 2'b01, 2'b10, 3'b000};
   localparam logic [15:0] DEC_U = {7'b0000000, 2'b10, 2'b01, 2'b10, 3'b110};
   localparam logic [15:0] MADR  = {7'b0000000, 2'b00, 2'b00, 2'b01, 3'b000};
   localparam logic [15:0] MRD   = {7'b0000001, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] MRD_T = {7'b0000001, 2'b00, 2'b00, 2'b00, 3'b001};
   localparam logic [15:0] MWB   = {7'b0010000, 2'b01, 2'b00, 2'b00, 3'b100};
   localparam logic [15:0] MWR   = {7'b0001001, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] MWR_D = {7'b0001001, 2'b00, 2'b00, 2'b00, 3'b100};
   localparam logic [15:0] MWR_T = {7'b0001001, 2'b00, 2'b00, 2'b00, 3'b001};
   localparam logic [15:0] EXR   = {7'b0000010, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] EXI   = {7'b0000010, 2'b00, 2'b00, 2'b01, 3'b000};
   localparam logic [15:0] AWB   = {7'b0010000, 2'b00, 2'b00, 2'b00, 3'b100};
   localparam logic [15:0] BR    = {7'b0000100, 2'b10, 2'b00, 2'b01, 3'b100};

   typedef struct {
      string       name;
      logic        rst;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic        ready;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] expQ[$];
   string       nameQ[$];
   int          total = 0;
   int          bad = 0;

   multicycle_mainfsm #(.MAXWAIT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .MemReady   (MemReady),
      .IRWrite    (IRWrite),
      .NextPC     (NextPC),
      .RegW       (RegW),
      .MemW       (MemW),
      .Branch     (Branch),
      .ALUOp      (ALUOp),
      .AdrSrc     (AdrSrc),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .InstrDone  (InstrDone),
      .Undef      (Undef),
      .MemTimeout (MemTimeout)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic addVec(input string n, input logic r, input logic [1:0] o,
                         input logic [5:0] f, input logic rdy, input logic [15:0] e);
      vec_t v;
      v.name = n; v.rst = r; v.op = o; v.funct = f; v.ready = rdy; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic checkOutput();
      logic [15:0] e;
      string       n;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard: got %b with no expected entry queued", act);
      end else begin
         e = expQ.pop_front();
         n = nameQ.pop_front();
         if (act !== e) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", n, act, e);
         end
      end
   endtask

   // Drive one cycle of inputs just after the edge, then compare mid-cycle.
   task automatic applyStimulus(input string n, input logic r, input logic [1:0] o,
                                input logic [5:0] f, input logic rdy, input logic [15:0] e);
      @(posedge clk);
      #1;
      reset    = r;
      Op       = o;
      Funct    = f;
      MemReady = rdy;
      expQ.push_back(e);
      nameQ.push_back(n);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      applyStimulus("reset", 1'b1, 2'b00, 6'b000000, 1'b0, F_B);
   endtask

   initial begin
      // Reset behaviour, ADD/ADDI, LDR with stalls, B, undefined opcode.
      addVec("rst_ready0", 1, 2'b00, 6'b000000, 0, F_B);
      addVec("rst_ready1", 1, 2'b00, 6'b000000, 1, F_B);
      addVec("add_fetch",  0, 2'b00, 6'b000000, 1, F_R);
      addVec("add_decode", 0, 2'b00, 6'b000000, 1, DEC);
      addVec("add_execr",  0, 2'b11, 6'b100001, 1, EXR);
      addVec("add_aluwb",  0, 2'b11, 6'b100001, 1, AWB);
      addVec("addi_fetch", 0, 2'b00, 6'b000000, 1, F_R);
      addVec("addi_dec",   0, 2'b00, 6'b100000, 1, DEC);
      addVec("addi_execi", 0, 2'b00, 6'b000000, 1, EXI);
      addVec("addi_aluwb", 0, 2'b00, 6'b000000, 1, AWB);
      addVec("ldr_fetch",  0, 2'b01, 6'b000001, 1, F_R);
      addVec("ldr_decode", 0, 2'b01, 6'b000001, 1, DEC);
      addVec("ldr_memadr", 0, 2'b01, 6'b000001, 1, MADR);
      addVec("ldr_wait1",  0, 2'b00, 6'b000000, 0, MRD);
      addVec("ldr_wait2",  0, 2'b10, 6'b000000, 0, MRD);
      addVec("ldr_wait3",  0, 2'b11, 6'b000000, 0, MRD);
      addVec("ldr_read",   0, 2'b00, 6'b000000, 1, MRD);
      addVec("ldr_memwb",  0, 2'b00, 6'b000000, 1, MWB);
      addVec("b_fetch",    0, 2'b10, 6'b000000, 1, F_R);
      addVec("b_decode",   0, 2'b10, 6'b000000, 1, DEC);
      addVec("b_branch",   0, 2'b10, 6'b000000, 1, BR);
      addVec("und_fetch",  0, 2'b11, 6'b000000, 1, F_R);
      addVec("und_decode", 0, 2'b11, 6'b000000, 1, DEC_U);
      addVec("und_refetch",0, 2'b11, 6'b000000, 0, F_B);
      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].funct,
                       vecs[i].ready, vecs[i].exp);

      // STR stalled 14 cycles: MemW for 15 cycles, done on the 15th, no timeout.
      doReset();
      applyStimulus("str_fetch",  0, 2'b01, 6'b000000, 1, F_R);
      applyStimulus("str_decode", 0, 2'b01, 6'b000000, 1, DEC);
      applyStimulus("str_memadr", 0, 2'b01, 6'b000000, 1, MADR);
      for (int i = 0; i < 14; i++)
         applyStimulus("str_wait", 0, 2'b00, 6'b000000, 0, MWR);
      applyStimulus("str_done",   0, 2'b00, 6'b000000, 1, MWR_D);
      applyStimulus("str_next",   0, 2'b00, 6'b000000, 0, F_B);

      // Fetch stuck: timeout on the 16th cycle, then the count restarts from zero.
      doReset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 15; i++)
            applyStimulus("fetch_wait", 0, 2'b00, 6'b000000, 0, F_B);
         applyStimulus("fetch_timeout", 0, 2'b00, 6'b000000, 0, F_T);
      end
      applyStimulus("fetch_after_to", 0, 2'b00, 6'b000000, 0, F_B);

      // STR stalled past the limit: timeout with MemW still high, back to FETCH.
      doReset();
      applyStimulus("strto_fetch",  0, 2'b01, 6'b000000, 1, F_R);
      applyStimulus("strto_decode", 0, 2'b01, 6'b000000, 1, DEC);
      applyStimulus("strto_memadr", 0, 2'b01, 6'b000000, 1, MADR);
      for (int i = 0; i < 15; i++)
         applyStimulus("strto_wait", 0, 2'b00, 6'b000000, 0, MWR);
      applyStimulus("strto_timeout", 0, 2'b00, 6'b000000, 0, MWR_T);
      applyStimulus("strto_fetch2",  0, 2'b00, 6'b000000, 0, F_B);

      // LDR ready exactly at the limit completes; one more stall cycle times out.
      doReset();
      applyStimulus("ldrb_fetch",  0, 2'b01, 6'b000001, 1, F_R);
      applyStimulus("ldrb_decode", 0, 2'b01, 6'b000001, 1, DEC);
      applyStimulus("ldrb_memadr", 0, 2'b01, 6'b000001, 1, MADR);
      for (int i = 0; i < 15; i++)
         applyStimulus("ldrb_wait", 0, 2'b01, 6'b000001, 0, MRD);
      applyStimulus("ldrb_edge_ready", 0, 2'b01, 6'b000001, 1, MRD);
      applyStimulus("ldrb_memwb",      0, 2'b01, 6'b000001, 1, MWB);
      applyStimulus("ldrto_fetch",  0, 2'b01, 6'b000001, 1, F_R);
      applyStimulus("ldrto_decode", 0, 2'b01, 6'b000001, 1, DEC);
      applyStimulus("ldrto_memadr", 0, 2'b01, 6'b000001, 1, MADR);
      for (int i = 0; i < 15; i++)
         applyStimulus("ldrto_wait", 0, 2'b01, 6'b000001, 0, MRD);
      applyStimulus("ldrto_timeout", 0, 2'b01, 6'b000001, 0, MRD_T);
      applyStimulus("ldrto_fetch2",  0, 2'b01, 6'b000001, 0, F_B);

      // Reset in the middle of a store, then a branch: Branch in the third cycle.
      doReset();
      applyStimulus("rsw_fetch",  0, 2'b01, 6'b000000, 1, F_R);
      applyStimulus("rsw_decode", 0, 2'b01, 6'b000000, 1, DEC);
      applyStimulus("rsw_memadr", 0, 2'b01, 6'b000000, 1, MADR);
      applyStimulus("rsw_write",  0, 2'b01, 6'b000000, 0, MWR);
      applyStimulus("rsw_reset",  1, 2'b01, 6'b000000, 0, F_B);
      applyStimulus("rsw_b_fetch",  0, 2'b10, 6'b000000, 1, F_R);
      applyStimulus("rsw_b_decode", 0, 2'b10, 6'b000000, 1, DEC);
      applyStimulus("rsw_b_branch", 0, 2'b10, 6'b000000, 1, BR);
      applyStimulus("rsw_b_after",  0, 2'b10, 6'b000000, 0, F_B);

      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
